// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, forwarding selects,
// and the packed stage-control bundle with its canonical values.
// Pure declarations; no latency, no backpressure.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    // Operand source select for the EX-stage ALU inputs.
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    // Pipeline register controls, MSB first:
    // PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en, IF_ID_flush, ID_EX_flush, MEM_WB_flush
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP      = 8'b00000_000; // nothing loads, nothing flushes
    localparam ctrl_t CTRL_RUN      = 8'b11111_000; // every stage advances
    localparam ctrl_t CTRL_FREEZE   = 8'b00000_001; // pipeline held, WB gets a bubble
    localparam ctrl_t CTRL_BRANCH   = 8'b11111_110; // squash the two wrong-path slots
    localparam ctrl_t CTRL_LOAD_USE = 8'b00111_010; // hold PC/IF_ID, bubble into EX

    // True when a stage that writes dst produces the value that src reads.
    // Register 0 is hardwired, so it never matches.
    function automatic logic reg_match(input logic       wr_en,
                                       input logic [4:0] dst,
                                       input logic [4:0] src);
        return wr_en && (dst != 5'd0) && (dst == src);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the datapath and the hazard controller: hazard inputs in, stage controls out.
// No latency of its own (wires only).
// No backpressure; the controller's enables are the pipeline's backpressure.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    import pipe_ctrl_pkg::*;

    // Datapath -> controller
    logic [4:0]       ID_rs;
    logic [4:0]       ID_rt;
    logic             ID_uses_rt;
    logic             EX_MemRead;
    logic             EX_RegWrite;
    logic [4:0]       EX_write_register;
    logic [4:0]       EX_rs;
    logic [4:0]       EX_rt;
    logic             MEM_RegWrite;
    logic [4:0]       MEM_write_register;
    logic             WB_RegWrite;
    logic [4:0]       WB_write_register;
    logic             branch_taken;
    logic             dmem_req;
    logic             dmem_ready;

    // Controller -> datapath
    logic             PC_en;
    logic             IF_ID_en;
    logic             ID_EX_en;
    logic             EX_MEM_en;
    logic             MEM_WB_en;
    logic             IF_ID_flush;
    logic             ID_EX_flush;
    logic             MEM_WB_flush;
    fwd_sel_t         forward_A;
    fwd_sel_t         forward_B;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output ID_rs, ID_rt, ID_uses_rt, EX_MemRead, EX_RegWrite, EX_write_register,
               EX_rs, EX_rt, MEM_RegWrite, MEM_write_register, WB_RegWrite,
               WB_write_register, branch_taken, dmem_req, dmem_ready,
        input  PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en, IF_ID_flush,
               ID_EX_flush, MEM_WB_flush, forward_A, forward_B, halted,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  ID_rs, ID_rt, ID_uses_rt, EX_MemRead, EX_RegWrite, EX_write_register,
               EX_rs, EX_rt, MEM_RegWrite, MEM_write_register, WB_RegWrite,
               WB_write_register, branch_taken, dmem_req, dmem_ready,
        output PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en, IF_ID_flush,
               ID_EX_flush, MEM_WB_flush, forward_A, forward_B, halted,
               stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd.sv
// pipe_fwd_unit: picks the ALU operand source for one EX source register.
// Latency: purely combinational.
// Backpressure: none.
// Ports: i_src (EX source reg), i_mem_* / i_wb_* (producer write-enable + dest), o_sel (select).
module pipe_fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] i_src,
    input  logic       i_mem_regwrite,
    input  logic [4:0] i_mem_dst,
    input  logic       i_wb_regwrite,
    input  logic [4:0] i_wb_dst,
    output fwd_sel_t   o_sel
);

    always_comb begin
        // The EX/MEM result is younger than MEM/WB, so it wins when both match.
        if (reg_match(i_mem_regwrite, i_mem_dst, i_src)) begin
            o_sel = FWD_MEM;
        end else if (reg_match(i_wb_regwrite, i_wb_dst, i_src)) begin
            o_sel = FWD_WB;
        end else begin
            o_sel = FWD_RF;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/forward sequencer for the 5-stage pipeline (RUN/MEM_WAIT/HALT FSM).
// Latency: controls are combinational from state+inputs; state, timeout and counters update next edge.
// Backpressure: a pending data-memory access freezes every stage; a timeout freezes it until rst.
// Ports: clk, rst (sync, active-high); bus (slave modport) carries hazard inputs, stage
//        enables/flushes, forward_A/B, halted, stall_cnt and flush_cnt.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 256,
    parameter int CNT_W       = 32
)(
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    ctrl_t            w_ctrl;
    ctrl_t            w_issue_ctrl;
    logic             w_mem_stall;
    logic             w_load_use;
    logic             w_frozen;
    logic             w_flush_evt;
    fwd_sel_t         w_fwd_a;
    fwd_sel_t         w_fwd_b;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    assign w_mem_stall = bus.dmem_req && !bus.dmem_ready;

    // A load in EX whose result the ID instruction needs: one bubble lets the
    // load reach MEM, after which forwarding from MEM/WB covers the rest.
    assign w_load_use = bus.EX_MemRead &&
                        (reg_match(bus.EX_RegWrite, bus.EX_write_register, bus.ID_rs) ||
                         (bus.ID_uses_rt &&
                          reg_match(bus.EX_RegWrite, bus.EX_write_register, bus.ID_rt)));

    // Controls for a cycle in which the pipeline is free to move.
    // A taken branch squashes the ID instruction anyway, so it beats load-use.
    always_comb begin
        w_issue_ctrl = CTRL_RUN;
        if (bus.branch_taken) begin
            w_issue_ctrl = CTRL_BRANCH;
        end else if (w_load_use) begin
            w_issue_ctrl = CTRL_LOAD_USE;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RUN: begin
                if (w_mem_stall) begin
                    // The entry cycle already counts as the first wait cycle.
                    w_next_state = (MEM_TIMEOUT <= 1) ? HALT : MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (bus.dmem_ready) begin
                    w_next_state = RUN;
                end else if (r_tmo_cnt >= TMO_W'(MEM_TIMEOUT - 1)) begin
                    w_next_state = HALT;
                end
            end
            HALT:    w_next_state = HALT;
            default: w_next_state = RUN;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_frozen = 1'b1;
        case (r_state)
            RUN:      w_frozen = w_mem_stall;
            MEM_WAIT: w_frozen = !bus.dmem_ready;
            HALT:     w_frozen = 1'b1;
            default:  w_frozen = 1'b1;
        endcase
    end

    // While frozen, EX simply holds a taken branch; it is acted on in the
    // release cycle, so a flush is only counted when the pipeline moves.
    assign w_ctrl      = w_frozen ? CTRL_FREEZE : w_issue_ctrl;
    assign w_flush_evt = !w_frozen && bus.branch_taken;

    assign bus.PC_en        = w_ctrl.pc_en;
    assign bus.IF_ID_en     = w_ctrl.if_id_en;
    assign bus.ID_EX_en     = w_ctrl.id_ex_en;
    assign bus.EX_MEM_en    = w_ctrl.ex_mem_en;
    assign bus.MEM_WB_en    = w_ctrl.mem_wb_en;
    assign bus.IF_ID_flush  = w_ctrl.if_id_flush;
    assign bus.ID_EX_flush  = w_ctrl.id_ex_flush;
    assign bus.MEM_WB_flush = w_ctrl.mem_wb_flush;
    assign bus.halted       = (r_state == HALT);

    // ------------------------------------------------------------------
    // Memory-wait timeout counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_mem_stall) begin
                        r_tmo_cnt <= TMO_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (!bus.dmem_ready) begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    end
                end
                default: r_tmo_cnt <= r_tmo_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!w_ctrl.pc_en && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush_evt && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;

    // ------------------------------------------------------------------
    // Operand forwarding: A follows EX_rs, B follows EX_rt
    // ------------------------------------------------------------------
    pipe_fwd_unit u_fwd_a (
        .i_src          (bus.EX_rs),
        .i_mem_regwrite (bus.MEM_RegWrite),
        .i_mem_dst      (bus.MEM_write_register),
        .i_wb_regwrite  (bus.WB_RegWrite),
        .i_wb_dst       (bus.WB_write_register),
        .o_sel          (w_fwd_a)
    );

    pipe_fwd_unit u_fwd_b (
        .i_src          (bus.EX_rt),
        .i_mem_regwrite (bus.MEM_RegWrite),
        .i_mem_dst      (bus.MEM_write_register),
        .i_wb_regwrite  (bus.WB_RegWrite),
        .i_wb_dst       (bus.WB_write_register),
        .o_sel          (w_fwd_b)
    );

    assign bus.forward_A = w_fwd_a;
    assign bus.forward_B = w_fwd_b;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: scoreboarded per-cycle expectations of stage controls,
// forwarding selects, halted flag and performance counters.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_pipe_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    // {PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en, IF_ID_flush, ID_EX_flush, MEM_WB_flush}
    localparam logic [7:0] C_RUN = 8'b11111_000;
    localparam logic [7:0] C_FRZ = 8'b00000_001;
    localparam logic [7:0] C_LU  = 8'b00111_010;
    localparam logic [7:0] C_BR  = 8'b11111_110;

    logic clk = 1'b0;
    logic rst = 1'b0;

    pipe_hazard_ctrl_if #(.CNT_W(32)) bus ();

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] m_stall = '0;
    logic [31:0] m_flush = '0;
    logic [76:0] sb[$];
    string       nq[$];
    logic [76:0] got;
    logic [76:0] want;
    string       nm;

    function automatic logic [76:0] observed();
        return {bus.PC_en, bus.IF_ID_en, bus.ID_EX_en, bus.EX_MEM_en, bus.MEM_WB_en,
                bus.IF_ID_flush, bus.ID_EX_flush, bus.MEM_WB_flush,
                bus.forward_A, bus.forward_B, bus.halted, bus.stall_cnt, bus.flush_cnt};
    endfunction

    // Push the expected output for the current cycle, then advance the counter model
    // (counters are registered, so this cycle's effect shows next cycle).
    task automatic expect_cyc(input string n, input logic [7:0] c, input logic [1:0] fa,
                              input logic [1:0] fb, input logic h, input logic fl);
        sb.push_back({c, fa, fb, h, m_stall, m_flush});
        nq.push_back(n);
        if (!c[7] && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
        if (fl && m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 1;
    endtask

    task automatic idle();
        bus.ID_rs = 0; bus.ID_rt = 0; bus.ID_uses_rt = 0;
        bus.EX_MemRead = 0; bus.EX_RegWrite = 0; bus.EX_write_register = 0;
        bus.EX_rs = 0; bus.EX_rt = 0;
        bus.MEM_RegWrite = 0; bus.MEM_write_register = 0;
        bus.WB_RegWrite = 0; bus.WB_write_register = 0;
        bus.branch_taken = 0; bus.dmem_req = 0; bus.dmem_ready = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_stall = '0;
        m_flush = '0;
    endtask

    task automatic test_reset();
        do_reset();
        expect_cyc("reset", C_RUN, 2'b00, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        got = observed(); want = sb.pop_front(); nm = nq.pop_front();
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_load_use();
        for (int i = 0; i < 6; i++) begin
            idle();
            case (i)
                0: begin // lw $2 in EX, add $3,$2,$4 in ID
                    bus.EX_MemRead = 1; bus.EX_RegWrite = 1; bus.EX_write_register = 2;
                    bus.ID_rs = 2; bus.ID_rt = 4; bus.ID_uses_rt = 1;
                    expect_cyc("lu_rs", C_LU, 2'b00, 2'b00, 1'b0, 1'b0);
                end
                1: begin // bubble now in EX, load in MEM
                    bus.ID_rs = 2; bus.ID_rt = 4; bus.ID_uses_rt = 1;
                    bus.MEM_RegWrite = 1; bus.MEM_write_register = 2;
                    expect_cyc("lu_after", C_RUN, 2'b00, 2'b00, 1'b0, 1'b0);
                end
                2: begin // match through rt
                    bus.EX_MemRead = 1; bus.EX_RegWrite = 1; bus.EX_write_register = 2;
                    bus.ID_rs = 7; bus.ID_rt = 2; bus.ID_uses_rt = 1;
                    expect_cyc("lu_rt", C_LU, 2'b00, 2'b00, 1'b0, 1'b0);
                end
                3: begin // rt matches but is not read
                    bus.EX_MemRead = 1; bus.EX_RegWrite = 1; bus.EX_write_register = 2;
                    bus.ID_rs = 7; bus.ID_rt = 2; bus.ID_uses_rt = 0;
                    expect_cyc("lu_rt_unused", C_RUN, 2'b00, 2'b00, 1'b0, 1'b0);
                end
                4: begin // load to $zero never stalls
                    bus.EX_MemRead = 1; bus.EX_RegWrite = 1; bus.EX_write_register = 0;
                    bus.ID_rs = 0; bus.ID_rt = 0; bus.ID_uses_rt = 1;
                    expect_cyc("lu_zero", C_RUN, 2'b00, 2'b00, 1'b0, 1'b0);
                end
                default: begin // ALU op, not a load
                    bus.EX_MemRead = 0; bus.EX_RegWrite = 1; bus.EX_write_register = 2;
                    bus.ID_rs = 2; bus.ID_uses_rt = 1;
                    expect_cyc("lu_not_load", C_RUN, 2'b00, 2'b00, 1'b0, 1'b0);
                end
            endcase
            @(negedge clk);
            got = observed(); want = sb.pop_front(); nm = nq.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL %s: got %h want %h", nm, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        for (int i = 0; i < 4; i++) begin
            idle();
            if (i == 0) begin // branch with a simultaneous load-use
                bus.branch_taken = 1;
                bus.EX_MemRead = 1; bus.EX_RegWrite = 1; bus.EX_write_register = 2;
                bus.ID_rs = 2; bus.ID_uses_rt = 1;
                expect_cyc("br_over_lu", C_BR, 2'b00, 2'b00, 1'b0, 1'b1);
            end else if (i == 2) begin
                bus.branch_taken = 1;
                expect_cyc("br_plain", C_BR, 2'b00, 2'b00, 1'b0, 1'b1);
            end else begin
                expect_cyc("br_after", C_RUN, 2'b00, 2'b00, 1'b0, 1'b0);
            end
            @(negedge clk);
            got = observed(); want = sb.pop_front(); nm = nq.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL %s: got %h want %h", nm, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_wait();
        // Three frozen cycles, release on the fourth, then plain RUN.
        // Second pass holds a taken branch through the wait.
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 5; i++) begin
                idle();
                bus.branch_taken = (pass == 1) && (i < 4);
                if (i < 4) begin
                    bus.dmem_req   = 1;
                    bus.dmem_ready = (i == 3);
                end
                if (i < 3)
                    expect_cyc("mw_frozen", C_FRZ, 2'b00, 2'b00, 1'b0, 1'b0);
                else if (i == 3 && pass == 1)
                    expect_cyc("mw_release_br", C_BR, 2'b00, 2'b00, 1'b0, 1'b1);
                else
                    expect_cyc("mw_release", C_RUN, 2'b00, 2'b00, 1'b0, 1'b0);
                @(negedge clk);
                got = observed(); want = sb.pop_front(); nm = nq.pop_front();
                n_cmp++;
                if (got !== want) begin
                    n_err++;
                    $display("FAIL %s: got %h want %h", nm, got, want);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_forward();
        logic [4:0] t_rs[5]   = '{5'd5, 5'd5, 5'd5, 5'd0, 5'd3};
        logic [4:0] t_rt[5]   = '{5'd5, 5'd6, 5'd6, 5'd0, 5'd9};
        logic       t_mrw[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [4:0] t_mdst[5] = '{5'd5, 5'd0, 5'd5, 5'd0, 5'd9};
        logic       t_wrw[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [4:0] t_wdst[5] = '{5'd5, 5'd5, 5'd6, 5'd0, 5'd3};
        logic [1:0] t_fa[5]   = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b01};
        logic [1:0] t_fb[5]   = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
        for (int i = 0; i < 5; i++) begin
            idle();
            bus.EX_rs = t_rs[i]; bus.EX_rt = t_rt[i];
            bus.MEM_RegWrite = t_mrw[i]; bus.MEM_write_register = t_mdst[i];
            bus.WB_RegWrite = t_wrw[i]; bus.WB_write_register = t_wdst[i];
            expect_cyc($sformatf("fwd_%0d", i), C_RUN, t_fa[i], t_fb[i], 1'b0, 1'b0);
            @(negedge clk);
            got = observed(); want = sb.pop_front(); nm = nq.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL %s: got %h want %h", nm, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        do_reset();
        // MEM_TIMEOUT=4: halted shows after the 4th wait cycle and ignores dmem_ready.
        for (int i = 0; i < 7; i++) begin
            idle();
            if (i < 6) begin
                bus.dmem_req   = 1;
                bus.dmem_ready = (i == 5);
                expect_cyc("tmo_wait", C_FRZ, 2'b00, 2'b00, (i >= 4), 1'b0);
            end else begin
                do_reset();
                expect_cyc("tmo_rst", C_RUN, 2'b00, 2'b00, 1'b0, 1'b0);
            end
            @(negedge clk);
            got = observed(); want = sb.pop_front(); nm = nq.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL %s: got %h want %h", nm, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rst_mid_wait();
        for (int i = 0; i < 3; i++) begin
            idle();
            if (i < 2) begin
                bus.dmem_req = 1;
                bus.branch_taken = 1;
                expect_cyc("rstw_wait", C_FRZ, 2'b00, 2'b00, 1'b0, 1'b0);
            end else begin
                do_reset();
                expect_cyc("rstw_after", C_RUN, 2'b00, 2'b00, 1'b0, 1'b0);
            end
            @(negedge clk);
            got = observed(); want = sb.pop_front(); nm = nq.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL %s: got %h want %h", nm, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        idle();
        @(posedge clk); #1;
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_forward();
        test_timeout();
        test_rst_mid_wait();
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
